// File: rtl/ras_ctrl.sv
// Return address stack controller: a speculative stack driven by fetch and a
// committed stack driven by retirement. A backend flush resynchronises the
// speculative stack from the committed one with a STACK_DEPTH-cycle copy.
module ras_ctrl #(
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_push_i,
  input  logic        f_pop_i,
  input  logic [29:0] f_din_i,
  output logic [29:0] f_top_o,
  output logic        f_top_valid_o,
  output logic        f_ready_o,
  input  logic        c_push_i,
  input  logic        c_pop_i,
  input  logic [29:0] c_din_i,
  input  logic        flush_i,
  output logic        busy_o
);

  localparam int unsigned PTR_WIDTH = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;
  localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);
  localparam logic [PTR_WIDTH-1:0] IDX_LAST = PTR_WIDTH'(STACK_DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(STACK_DEPTH);

  typedef enum logic {
    IDLE,
    RESTORE
  } state_t;

  // Result of one stack operation: optional write plus next pointer/count.
  typedef struct packed {
    logic                 we;
    logic [PTR_WIDTH-1:0] waddr;
    logic [PTR_WIDTH-1:0] ptr;
    logic [CNT_WIDTH-1:0] cnt;
  } stk_upd_t;

  // Shared push/pop/replace-top rule used by both stacks.
  function automatic stk_upd_t stk_step(
    input logic                 push,
    input logic                 pop,
    input logic [PTR_WIDTH-1:0] ptr,
    input logic [CNT_WIDTH-1:0] cnt
  );
    stk_upd_t r;
    r.we    = 1'b0;
    r.waddr = ptr;
    r.ptr   = ptr;
    r.cnt   = cnt;
    if (push && pop && (cnt != '0)) begin
      // Replace top in place; depth unchanged.
      r.we    = 1'b1;
      r.waddr = ptr - PTR_ONE;
    end else if (push) begin
      // A full stack silently overwrites its oldest entry via pointer wrap.
      r.we    = 1'b1;
      r.waddr = ptr;
      r.ptr   = ptr + PTR_ONE;
      r.cnt   = (cnt == CNT_FULL) ? cnt : cnt + CNT_ONE;
    end else if (pop && (cnt != '0)) begin
      r.ptr = ptr - PTR_ONE;
      r.cnt = cnt - CNT_ONE;
    end
    return r;
  endfunction

  logic [29:0] spec_mem [STACK_DEPTH];
  logic [29:0] com_mem  [STACK_DEPTH];

  state_t               state_q, state_d;
  logic [PTR_WIDTH-1:0] spec_ptr_q, spec_ptr_d;
  logic [CNT_WIDTH-1:0] spec_cnt_q, spec_cnt_d;
  logic [PTR_WIDTH-1:0] com_ptr_q;
  logic [CNT_WIDTH-1:0] com_cnt_q;
  logic [PTR_WIDTH-1:0] idx_q, idx_d;

  stk_upd_t             com_upd;
  stk_upd_t             fetch_upd;
  stk_upd_t             mirror_upd;
  logic                 ready;
  logic                 copy_en;
  logic                 spec_we;
  logic [PTR_WIDTH-1:0] spec_waddr;
  logic [29:0]          spec_wdata;
  logic [29:0]          spec_top_raw;

  // Candidate updates: committed stack, fetch-driven and commit-mirrored spec.
  always_comb begin
    ready      = (state_q == IDLE) && !flush_i;
    com_upd    = stk_step(c_push_i, c_pop_i, com_ptr_q, com_cnt_q);
    fetch_upd  = stk_step(f_push_i && ready, f_pop_i && ready, spec_ptr_q, spec_cnt_q);
    mirror_upd = stk_step(c_push_i, c_pop_i, spec_ptr_q, spec_cnt_q);
  end

  // Next-state and speculative-stack control.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    spec_ptr_d = spec_ptr_q;
    spec_cnt_d = spec_cnt_q;
    spec_we    = 1'b0;
    spec_waddr = '0;
    spec_wdata = '0;
    copy_en    = 1'b0;
    f_ready_o  = ready;
    busy_o     = (state_q == RESTORE);
    if (flush_i) begin
      // Pointers snap to the committed stack (including this cycle's commit op);
      // contents follow during the copy sequence.
      state_d    = RESTORE;
      idx_d      = '0;
      spec_ptr_d = com_upd.ptr;
      spec_cnt_d = com_upd.cnt;
    end else begin
      unique case (state_q)
        IDLE: begin
          spec_ptr_d = fetch_upd.ptr;
          spec_cnt_d = fetch_upd.cnt;
          spec_we    = fetch_upd.we;
          spec_waddr = fetch_upd.waddr;
          spec_wdata = f_din_i;
        end
        RESTORE: begin
          // Copy one entry per cycle; commit ops are mirrored so entries
          // already copied stay coherent.
          copy_en    = 1'b1;
          spec_ptr_d = mirror_upd.ptr;
          spec_cnt_d = mirror_upd.cnt;
          spec_we    = mirror_upd.we;
          spec_waddr = mirror_upd.waddr;
          spec_wdata = c_din_i;
          idx_d      = idx_q + PTR_ONE;
          if (idx_q == IDX_LAST) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Storage writes; copy reads the old committed value, mirrored write wins.
  always_ff @(posedge clk) begin
    if (com_upd.we) begin
      com_mem[com_upd.waddr] <= c_din_i;
    end
    if (copy_en) begin
      spec_mem[idx_q] <= com_mem[idx_q];
    end
    if (spec_we) begin
      spec_mem[spec_waddr] <= spec_wdata;
    end
  end

  // Control state with asynchronous reset; array contents are left as-is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      spec_ptr_q <= '0;
      spec_cnt_q <= '0;
      com_ptr_q  <= '0;
      com_cnt_q  <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      spec_ptr_q <= spec_ptr_d;
      spec_cnt_q <= spec_cnt_d;
      com_ptr_q  <= com_upd.ptr;
      com_cnt_q  <= com_upd.cnt;
      idx_q      <= idx_d;
    end
  end

  // Speculative top is a combinational read, forced to zero when not valid.
  always_comb begin
    spec_top_raw  = spec_mem[spec_ptr_q - PTR_ONE];
    f_top_valid_o = (spec_cnt_q != '0) && (state_q == IDLE);
    f_top_o       = f_top_valid_o ? spec_top_raw : 30'd0;
  end

endmodule

// File: tb/tb_ras_ctrl.sv
// Testbench for ras_ctrl: directed scenarios followed by random traffic, all
// checked against a queue-based model of the two stacks.
module tb_ras_ctrl;

  localparam int DEPTH = 8;

  typedef logic [29:0] addr_q_t[$];

  logic        clk;
  logic        rst_n;
  logic        f_push_i, f_pop_i, c_push_i, c_pop_i, flush_i;
  logic [29:0] f_din_i, c_din_i;
  logic [29:0] f_top_o;
  logic        f_top_valid_o, f_ready_o, busy_o;

  int checks;
  int failures;
  int txn;

  // Model: stacks as queues (back = top), restore as a remaining-cycle count.
  addr_q_t m_spec;
  addr_q_t m_com;
  int      m_busy_left;

  ras_ctrl #(.STACK_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .f_push_i      (f_push_i),
    .f_pop_i       (f_pop_i),
    .f_din_i       (f_din_i),
    .f_top_o       (f_top_o),
    .f_top_valid_o (f_top_valid_o),
    .f_ready_o     (f_ready_o),
    .c_push_i      (c_push_i),
    .c_pop_i       (c_pop_i),
    .c_din_i       (c_din_i),
    .flush_i       (flush_i),
    .busy_o        (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic addr_q_t stack_op(addr_q_t q, logic push, logic pop, logic [29:0] d);
    addr_q_t r = q;
    if (push && pop && r.size() > 0) begin
      r[r.size()-1] = d;
    end else if (push) begin
      r.push_back(d);
      if (r.size() > DEPTH) void'(r.pop_front());
    end else if (pop && r.size() > 0) begin
      void'(r.pop_back());
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic        exp_valid;
    logic [29:0] exp_top;
    exp_valid = (m_busy_left == 0) && (m_spec.size() > 0);
    exp_top   = exp_valid ? m_spec[m_spec.size()-1] : 30'd0;
    check({tag, "_valid"}, {31'd0, f_top_valid_o}, {31'd0, exp_valid});
    check({tag, "_top"},   {2'd0, f_top_o},        {2'd0, exp_top});
    check({tag, "_busy"},  {31'd0, busy_o},        {31'd0, m_busy_left != 0});
  endtask

  // One clock cycle: drive, check ready, clock, update model, check outputs.
  task automatic cycle(input string tag, input logic fp, input logic fpo, input logic [29:0] fd,
                       input logic cp, input logic cpo, input logic [29:0] cd, input logic fl);
    logic ready_exp;
    f_push_i = fp; f_pop_i = fpo; f_din_i = fd;
    c_push_i = cp; c_pop_i = cpo; c_din_i = cd;
    flush_i  = fl;
    #1;
    ready_exp = (m_busy_left == 0) && !fl;
    check({tag, "_ready"}, {31'd0, f_ready_o}, {31'd0, ready_exp});
    @(posedge clk);
    m_com = stack_op(m_com, cp, cpo, cd);
    if (fl) begin
      m_spec      = m_com;
      m_busy_left = DEPTH;
    end else if (m_busy_left != 0) begin
      m_spec = stack_op(m_spec, cp, cpo, cd);
      m_busy_left--;
    end else if (ready_exp) begin
      m_spec = stack_op(m_spec, fp, fpo, fd);
    end
    @(negedge clk);
    check_outputs(tag);
    txn++;
    $display("txn %0d %s fpush=%b fpop=%b fdin=%h cpush=%b cpop=%b cdin=%h flush=%b -> top=%h valid=%b busy=%b",
             txn, tag, fp, fpo, fd, cp, cpo, cd, fl, f_top_o, f_top_valid_o, busy_o);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, 1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 1'b0);
  endtask

  task automatic model_reset();
    m_spec.delete();
    m_com.delete();
    m_busy_left = 0;
  endtask

  initial begin
    int busy_cnt;
    checks = 0; failures = 0; txn = 0;
    f_push_i = 0; f_pop_i = 0; f_din_i = '0;
    c_push_i = 0; c_pop_i = 0; c_din_i = '0; flush_i = 0;
    model_reset();

    // Reset state
    rst_n = 1'b0;
    #2;
    check("rst_top",   {2'd0, f_top_o},        32'd0);
    check("rst_valid", {31'd0, f_top_valid_o}, 32'd0);
    check("rst_ready", {31'd0, f_ready_o},     32'd1);
    check("rst_busy",  {31'd0, busy_o},        32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic fetch push/pop and underflow
    cycle("p100", 1, 0, 30'h100, 0, 0, 0, 0);
    cycle("p200", 1, 0, 30'h200, 0, 0, 0, 0);
    check("basic_top200", {2'd0, f_top_o}, 32'h200);
    cycle("pop1", 0, 1, 0, 0, 0, 0, 0);
    check("basic_top100", {2'd0, f_top_o}, 32'h100);
    cycle("pop2", 0, 1, 0, 0, 0, 0, 0);
    cycle("pop3", 0, 1, 0, 0, 0, 0, 0);
    check("basic_empty", {31'd0, f_top_valid_o}, 32'd0);
    cycle("p_after_empty", 1, 0, 30'h77, 0, 0, 0, 0);
    cycle("pop_after_empty", 0, 1, 0, 0, 0, 0, 0);
    check("empty_again", {31'd0, f_top_valid_o}, 32'd0);

    // Flush restores committed contents after exactly DEPTH busy cycles
    cycle("cpushA", 0, 0, 0, 1, 0, 30'hA, 0);
    cycle("spushB", 1, 0, 30'hB, 0, 0, 0, 0);
    cycle("spushC", 1, 0, 30'hC, 0, 0, 0, 0);
    busy_cnt = 0;
    cycle("flush1", 1, 0, 30'hEE, 0, 0, 0, 1);
    busy_cnt += int'(busy_o);
    for (int i = 0; i < 12; i++) begin
      cycle("rest1", 1, 0, 30'hEE, 0, 0, 0, 0);
      busy_cnt += int'(busy_o);
    end
    check("flush1_busy_cycles", busy_cnt, 32'd8);
    // The pushes of 0xEE after restore completes are legitimate; pop them off.
    while (m_spec.size() > 1) cycle("popEE", 0, 1, 0, 0, 0, 0, 0);
    check("flush1_topA", {2'd0, f_top_o}, 32'hA);

    // Commit pushes in restore cycles 0 and 5 are mirrored
    cycle("flush2", 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 0 || i == 5) cycle("rest2_c", 0, 0, 0, 1, 0, 30'hD, 0);
      else                  idle("rest2");
    end
    check("flush2_topD", {2'd0, f_top_o}, 32'hD);
    check("flush2_depth", m_spec.size(), 32'd3);

    // Re-flush at restore cycle 3 restarts the full sequence
    cycle("flush3", 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) idle("rest3");
    busy_cnt = 0;
    cycle("reflush", 0, 0, 0, 0, 0, 0, 1);
    busy_cnt += int'(busy_o);
    for (int i = 0; i < 12; i++) begin
      idle("rest3b");
      busy_cnt += int'(busy_o);
    end
    check("reflush_busy_cycles", busy_cnt, 32'd8);
    cycle("popD1", 0, 1, 0, 0, 0, 0, 0);
    cycle("popD2", 0, 1, 0, 0, 0, 0, 0);
    check("cnt1_topA", {2'd0, f_top_o}, 32'hA);
    cycle("replace", 1, 1, 30'h55, 0, 0, 0, 0);
    check("replace_top", {2'd0, f_top_o}, 32'h55);
    cycle("pop_repl", 0, 1, 0, 0, 0, 0, 0);
    check("replace_cnt1", {31'd0, f_top_valid_o}, 32'd0);

    // Asynchronous reset mid-restore
    cycle("flush4", 0, 0, 0, 0, 0, 0, 1);
    idle("rest4");
    idle("rest4");
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_busy",  {31'd0, busy_o},        32'd0);
    check("arst_valid", {31'd0, f_top_valid_o}, 32'd0);
    check("arst_top",   {2'd0, f_top_o},        32'd0);
    check("arst_ready", {31'd0, f_ready_o},     32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Overfill by one then drain
    for (int v = 1; v <= 9; v++) cycle("fill", 1, 0, 30'(v), 0, 0, 0, 0);
    check("full_top9", {2'd0, f_top_o}, 32'd9);
    for (int k = 0; k < 8; k++) begin
      check("drain_top", {2'd0, f_top_o}, 32'(9 - k));
      cycle("drain", 0, 1, 0, 0, 0, 0, 0);
    end
    check("drain_empty", {31'd0, f_top_valid_o}, 32'd0);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      cycle("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 30'($urandom()),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), 30'($urandom()),
            ($urandom_range(0, 29) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ras_ctrl.md
RAS_CTRL -- requirements
Module: ras_ctrl

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 8, meaning entries per stack; power of two, >= 2; PTR_WIDTH = log2(STACK_DEPTH).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on posedge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port f_push_i  input  1  fetch-side speculative push (call predicted).
REQ-005 SHALL have port f_pop_i  input  1  fetch-side speculative pop (return predicted).
REQ-006 SHALL have port f_din_i  input  30 [31:2]  return address to push, fetch side.
REQ-007 SHALL have port f_top_o  output  30 [31:2]  speculative top of stack.
REQ-008 SHALL have port f_top_valid_o  output  1  f_top_o is meaningful.
REQ-009 SHALL have port f_ready_o  output  1  fetch push/pop accepted this cycle.
REQ-010 SHALL have port c_push_i  input  1  commit-side push (call retired).
REQ-011 SHALL have port c_pop_i  input  1  commit-side pop (return retired).
REQ-012 SHALL have port c_din_i  input  30 [31:2]  return address to push, commit side.
REQ-013 SHALL have port flush_i  input  1  backend redirect; discard speculative state.
REQ-014 SHALL have port busy_o  output  1  restore sequence in progress.

Function
REQ-015 SHALL keep two stacks: speculative (spec array, spec_ptr, spec_cnt) and committed (com array, com_ptr, com_cnt); ptr is PTR_WIDTH bits and wraps modulo STACK_DEPTH; cnt is 0..STACK_DEPTH and saturates.
REQ-016 Stack op rules, identical for both stacks: push only -> write arr[ptr], ptr+1, cnt = min(cnt+1, DEPTH); full push overwrites oldest entry.
REQ-017 Pop only -> ptr-1, cnt-1 when cnt>0; pop with cnt==0 is a no-op.
REQ-018 Push and pop in the same cycle -> replace top: write arr[ptr-1], ptr and cnt unchanged; if cnt==0, behave as push only.
REQ-019 FSM states: IDLE, RESTORE; f_ready_o = (state==IDLE) && !flush_i; busy_o = (state==RESTORE).
REQ-020 Fetch ops SHALL update the spec stack only when f_ready_o=1; otherwise they are ignored (not queued).
REQ-021 f_top_o = spec[spec_ptr-1] combinationally; f_top_valid_o = (spec_cnt!=0) && state==IDLE; f_top_o SHALL be 0 when f_top_valid_o=0.
REQ-022 Commit ops SHALL update the com stack every cycle in every state, zero latency.
REQ-023 flush_i in any state: next spec_ptr/spec_cnt = com_ptr/com_cnt after applying the same-cycle commit op; state -> RESTORE; restore index idx -> 0.
REQ-024 RESTORE: each cycle copy com[idx] to spec[idx], idx+1; after the cycle with idx==DEPTH-1, state -> IDLE; duration exactly STACK_DEPTH cycles.
REQ-025 During RESTORE a commit op SHALL be mirrored onto the spec stack (same write, same ptr/cnt update); when the mirrored write and the copy target the same index, the mirrored write wins.
REQ-026 flush_i during RESTORE SHALL restart the sequence (idx -> 0, full STACK_DEPTH cycles again).
REQ-027 Copy reads SHALL observe com contents before the same-cycle commit write (old value); REQ-025 keeps spec coherent.

Reset
REQ-028 On rst_n low, asynchronously: state=IDLE, spec_ptr=com_ptr=0, spec_cnt=com_cnt=0, idx=0.
REQ-029 Outputs during/after reset: f_top_o=0, f_top_valid_o=0, f_ready_o=1 (flush_i low), busy_o=0.
REQ-030 Array contents SHALL NOT be reset; reset asserted mid-RESTORE aborts it immediately.

Verification
REQ-031 Push 0x100,0x200 fetch-side -> f_top_o=0x200 valid; one pop -> 0x100; pop twice more -> valid=0, top=0, cnt stays 0.
REQ-032 DEPTH=8: push 9 values 1..9 -> cnt=8, top=9; 8 pops return 9..2, then valid=0.
REQ-033 Commit push 0xA; spec push 0xB,0xC; flush -> busy_o=1 for exactly 8 cycles, f_ready_o=0; then top=0xA, cnt=1.
REQ-034 Commit push 0xD in restore cycle 0 and 5 -> after restore top=0xD, spec_cnt = com_cnt.
REQ-035 Flush at restore cycle 3 -> busy_o stays high 8 more cycles; simultaneous fetch push+pop on cnt=1 -> top replaced, cnt=1.
REQ-036 rst_n low mid-RESTORE -> busy_o=0, f_top_valid_o=0 with no clock edge.
